// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RV32M multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a; holds the FSM state enum, funct3 op encodings, sizing constants and signedness helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // funct3 encodings of the RV32M ops
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int          ITER_CNT  = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // MUL is treated as signed x signed; its low product word is identical either way.
    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring shift-subtract divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
// Ports: is_div selects divide; hi/lo are the accumulator/operand pair; b is the multiplicand or divisor.
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] b,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_sub;

    always_comb begin
        // multiply: conditionally add the multiplicand, then shift {carry,hi,lo} right
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
        // divide: shift the next dividend bit into the partial remainder
        rem_sh  = {hi, lo[31]};
        fits    = (rem_sh >= {1'b0, b});
        // when it fits the difference is below b, so the low 32 bits are exact
        rem_sub = rem_sh[31:0] - b;
        if (is_div) begin
            hi_nxt = fits ? rem_sub : rem_sh[31:0];
            lo_nxt = {lo[30:0], fits};
        end else begin
            hi_nxt = sum[32:1];
            lo_nxt = {sum[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32 iteration cycles on magnitudes, then sign fixup.
// Latency: start at edge 0 -> done in cycle 34; divide-by-zero and INT_MIN/-1 finish in cycle 1.
// Backpressure: stall = start & ~done holds the core; flush or rst abort with no done pulse.
// Ports: clk, rst, start, op(funct3), rs1, rs2, flush in; stall, busy, done, result out.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic        a_neg, b_neg;
    logic [31:0] hi, lo, b_mag;
    logic [4:0]  cnt;
    logic [31:0] hi_step, lo_step;

    logic        accept, is_div0, is_ovf, special;
    logic [31:0] special_res;
    logic        a_in_neg, b_in_neg;
    logic [31:0] a_in_mag, b_in_mag;
    logic [63:0] prod, prod_fix;
    logic [31:0] quot_fix, rem_fix, fix_res;

    // ---------------- operand decode at acceptance ----------------
    assign accept   = (state == ST_IDLE) && start && !flush;
    assign is_div0  = op[2] && (rs2 == 32'd0);
    assign is_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);
    assign special  = is_div0 || is_ovf;
    assign a_in_neg = rs1_is_signed(op) && rs1[31];
    assign b_in_neg = rs2_is_signed(op) && rs2[31];
    assign a_in_mag = a_in_neg ? (~rs1 + 32'd1) : rs1;
    assign b_in_mag = b_in_neg ? (~rs2 + 32'd1) : rs2;

    // op[1] separates REM/REMU from DIV/DIVU
    always_comb begin
        special_res = 32'd0;
        if (is_div0)
            special_res = op[1] ? rs1 : DIV0_QUOT;
        else
            special_res = op[1] ? 32'd0 : INT_MIN;
    end

    muldiv_step u_step (
        .is_div (op_q[2]),
        .hi     (hi),
        .lo     (lo),
        .b      (b_mag),
        .hi_nxt (hi_step),
        .lo_nxt (lo_step)
    );

    // ---------------- sign fixup and word select ----------------
    always_comb begin
        prod     = {hi, lo};
        prod_fix = (a_neg ^ b_neg) ? (~prod + 64'd1) : prod;
        quot_fix = (a_neg ^ b_neg) ? (~lo + 32'd1) : lo;
        rem_fix  = a_neg ? (~hi + 32'd1) : hi;
        case (op_q)
            OP_MUL:                         fix_res = prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod_fix[63:32];
            OP_DIV, OP_DIVU:                fix_res = quot_fix;
            default:                        fix_res = rem_fix;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == 5'd0) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = (state != ST_IDLE);
        done  = (state == ST_DONE);
        stall = start && !done;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 3'd0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            b_mag  <= 32'd0;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else if (accept) begin
            op_q  <= op;
            a_neg <= a_in_neg;
            b_neg <= b_in_neg;
            hi    <= 32'd0;
            lo    <= a_in_mag;
            b_mag <= b_in_mag;
            cnt   <= 5'(ITER_CNT - 1);
            if (special)
                result <= special_res;
        end else if (state == ST_CALC && !flush) begin
            hi  <= hi_step;
            lo  <= lo_step;
            cnt <= cnt - 5'd1;
        end else if (state == ST_FIX && !flush) begin
            result <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with hand-computed RV32M results.
// Latency: checks done timing (cycle 34 normal, cycle 1 special cases) and stall coverage.
// Backpressure: exercises flush, mid-op reset, operand changes after acceptance and back-to-back ops.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Drives one op from the current cycle (cycle 0) until done; reports the done cycle,
    // the result seen with done, and how many cycles had a wrong stall value.
    // Operands are scrambled after acceptance. Leaves start low, #1 after the edge ending DONE.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int stall_bad);
        bit seen;
        lat = -1; res = 32'hxxxx_xxxx; stall_bad = 0; seen = 0;
        op = o; rs1 = a; rs2 = b; start = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1; lat = cyc; res = result;
                if (stall !== 1'b0) stall_bad++;
            end else if (stall !== 1'b1) begin
                stall_bad++;
            end
            @(posedge clk); #1;
            if (cyc == 0) begin
                rs1 = 32'hDEAD_BEEF; rs2 = 32'h1357_2468; op = ~o;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", stall); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL reset_result: got %h exp 0", result); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4]  = '{3'd0, 3'd3, 3'd2, 3'd1};
        logic [31:0] as  [4]  = '{32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs  [4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exp [4]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};
        int lat, sb; logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, sb);
            n_checks++; if (res !== exp[i]) $display("FAIL mul%0d_result: got %h exp %h", i, res, exp[i]); else n_pass++;
            n_checks++; if (lat !== 34) $display("FAIL mul%0d_latency: got %0d exp 34", i, lat); else n_pass++;
            n_checks++; if (sb !== 0) $display("FAIL mul%0d_stall: got %0d bad cycles exp 0", i, sb); else n_pass++;
        end
        // one cycle after done: back in IDLE, pulse gone, result held
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL done_pulse_width: got %b exp 0", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_after_done: got %b exp 0", busy); else n_pass++;
        n_checks++; if (result !== 32'h4000_0000) $display("FAIL result_hold: got %h exp 40000000", result); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        logic [2:0]  ops [5]  = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
        logic [31:0] as  [5]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000};
        logic [31:0] bs  [5]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd2};
        logic [31:0] exp [5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hC000_0000};
        int lat, sb; logic [31:0] res;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, sb);
            n_checks++; if (res !== exp[i]) $display("FAIL div%0d_result: got %h exp %h", i, res, exp[i]); else n_pass++;
            n_checks++; if (lat !== 34) $display("FAIL div%0d_latency: got %0d exp 34", i, lat); else n_pass++;
            n_checks++; if (sb !== 0) $display("FAIL div%0d_stall: got %0d bad cycles exp 0", i, sb); else n_pass++;
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [6]  = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [6]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
        logic [31:0] bs  [6]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [6]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
        int lat, sb; logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, sb);
            n_checks++; if (res !== exp[i]) $display("FAIL special%0d_result: got %h exp %h", i, res, exp[i]); else n_pass++;
            n_checks++; if (lat !== 1) $display("FAIL special%0d_latency: got %0d exp 1", i, lat); else n_pass++;
        end
    endtask

    task automatic test_flush();
        int lat, sb, pulses; logic [31:0] res;
        // prior result is 9 from the last REMU 9/0
        op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;                       // cycle 10
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy_c10: got %b exp 1", busy); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;             // cycle 11
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_idle_c11: got %b exp 0", busy); else n_pass++;
        n_checks++; if (result !== 32'd9) $display("FAIL flush_result_kept: got %h exp 9", result); else n_pass++;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL flush_no_done: got %0d pulses exp 0", pulses); else n_pass++;
        // flush and start together in IDLE: flush wins
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'd5; rs1 = 32'd50; rs2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_beats_start: got %b exp 0", busy); else n_pass++;
        @(posedge clk); #1;
        do_op(3'd5, 32'd100, 32'd7, lat, res, sb);
        n_checks++; if (res !== 32'd14) $display("FAIL post_flush_result: got %h exp 0000000e", res); else n_pass++;
        n_checks++; if (lat !== 34) $display("FAIL post_flush_latency: got %0d exp 34", lat); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int pulses;
        op = 3'd0; rs1 = 32'd123; rs2 = 32'd456; start = 1'b1;
        repeat (20) @(posedge clk);
        #1; rst = 1'b1; start = 1'b0;           // cycle 20
        @(posedge clk); #1;
        rst = 1'b0;                             // cycle 21
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b exp 0", done); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b exp 0", stall); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL rst_mid_result: got %h exp 0", result); else n_pass++;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL rst_mid_no_done: got %0d pulses exp 0", pulses); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, sb1, sb2; logic [31:0] r1, r2;
        do_op(3'd0, 32'd1000, 32'd1000, lat1, r1, sb1);
        do_op(3'd7, 32'd1000, 32'd7, lat2, r2, sb2);   // starts in the IDLE cycle right after DONE
        n_checks++; if (r1 !== 32'd1000000) $display("FAIL b2b_first_result: got %h exp 000f4240", r1); else n_pass++;
        n_checks++; if (lat1 !== 34) $display("FAIL b2b_first_latency: got %0d exp 34", lat1); else n_pass++;
        n_checks++; if (r2 !== 32'd6) $display("FAIL b2b_second_result: got %h exp 6", r2); else n_pass++;
        n_checks++; if (lat2 !== 34) $display("FAIL b2b_second_latency: got %0d exp 34", lat2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; port names clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  decoder flags an RV32M op (opcode 0110011, funct7[0]=1); held high by core until done.
REQ-005 op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1  input  32  operand A.
REQ-007 rs2  input  32  operand B.
REQ-008 flush  input  1  abort current op, no writeback.
REQ-009 stall  output  1  combinational; start & ~done; freezes PC and regfile write.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse; result valid and regfile write permitted this cycle.
REQ-012 result  output  32  final value; held until next accepted start.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE.
REQ-014 IDLE & start SHALL latch op/rs1/rs2 and go to CALC, loading iteration counter with 31.
REQ-015 CALC SHALL perform one shift-add (mul) or restoring shift-subtract (div) step per cycle on magnitudes; counter 0 -> FIX.
REQ-016 FIX SHALL apply sign correction and select high/low product word or quotient/remainder; always -> DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then -> IDLE unconditionally; start seen in DONE is ignored.
REQ-018 Latency: start sampled at edge 0, CALC cycles 1-32, FIX cycle 33, done high in cycle 34.
REQ-019 Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/DIVU/REMU unsigned; product is 64-bit, MUL returns [31:0], MULH* return [63:32].
REQ-020 Remainder sign SHALL follow dividend; quotient sign = sign(rs1) xor sign(rs2).
REQ-021 Divide by zero: IDLE -> DONE directly (done in cycle 1); DIV/DIVU = 0xFFFFFFFF, REM/REMU = rs1.
REQ-022 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): IDLE -> DONE directly; DIV = 0x80000000, REM = 0.
REQ-023 flush in any state SHALL force IDLE next edge, no done, result unchanged; flush beats start in IDLE.
REQ-024 start deassertion mid-operation SHALL not abort; only flush or rst aborts.
REQ-025 Operand changes after acceptance SHALL not affect result.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, result 0, done 0, busy 0, internal accumulators 0, on the next rising edge.
REQ-027 rst mid-operation SHALL discard the op with no done pulse; rst overrides flush and start.

Structure
REQ-028 Shared package muldiv_pkg SHALL hold the state enum, op encodings, ITER_CNT=32, DIV0_QUOT=0xFFFFFFFF, INT_MIN=0x80000000.
REQ-029 One combinational sub-module muldiv_step SHALL implement a single add/subtract iteration; sequencing, counter and sign fixup stay in muldiv_seq.

Verification
REQ-030 MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done in cycle 34, result 0xFFFFFFEB; stall high cycles 0-33.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, all with done in cycle 1.
REQ-034 flush at cycle 10 of a DIV -> IDLE at cycle 11, no done, result keeps prior value; next start accepted normally.
REQ-035 rst at cycle 20 of a MUL -> all outputs 0 next cycle; back-to-back start after done accepted in following IDLE cycle.
